axis_bist_checker: RTL

- Receive-side BIST engine for the DRAM FIFO inline test path.
- Sits on the BIST output of the AXI DEMUX and consumes CVITA-framed 64-bit AXI-Stream packets that the BIST generator pushed through the DRAM FIFO.
- Regenerates the expected header and payload for each line, compares them against what arrives, and counts packets.
- Reports running, done and error status in the same 4-bit layout that software reads back.

---
 rtl/axis_bist_checker.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/axis_bist_checker.sv
// Receive-side BIST checker for the DRAM FIFO inline test path.
// Regenerates CVITA header/payload lines, compares incoming beats and reports status.
module axis_bist_checker #(
    parameter int DWIDTH    = 64,
    parameter int PKT_CNT_W = 18,
    parameter int LEN_W     = 13
) (
    input  logic                 bus_clk,
    input  logic                 bus_rst_n,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [1:0]           pattern,
    input  logic [31:0]          const_word,
    input  logic [31:0]          sid,
    input  logic [LEN_W-1:0]     pkt_len_bytes,
    input  logic [PKT_CNT_W-1:0] num_pkts,
    input  logic [DWIDTH-1:0]    i_tdata,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [3:0]           status,
    output logic [PKT_CNT_W-1:0] pkt_cnt,
    output logic [PKT_CNT_W-1:0] err_pkt
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    state_t               state, next_state;
    logic                 start_d;
    logic                 cfg_cont;
    logic [1:0]           cfg_pattern;
    logic [31:0]          cfg_const;
    logic [31:0]          cfg_sid;
    logic [LEN_W-1:0]     cfg_len;
    logic [PKT_CNT_W-1:0] cfg_num;
    logic [LEN_W-1:0]     cfg_last_k;
    logic [11:0]          seqnum;
    logic [LEN_W-1:0]     k;
    logic                 running_q;
    logic                 done_q;
    logic [1:0]           error_q;
    logic [PKT_CNT_W-1:0] pkt_cnt_q;
    logic [PKT_CNT_W-1:0] err_pkt_q;

    logic                 start_rise;
    logic                 zero_run;
    logic [LEN_W:0]       eff_len;
    logic [LEN_W:0]       nlines;
    logic [LEN_W-1:0]     last_k_next;
    logic [DWIDTH-1:0]    exp_hdr;
    logic [DWIDTH-1:0]    exp_data;
    logic [31:0]          ramp_word;
    logic                 last_line;
    logic [PKT_CNT_W-1:0] pkt_cnt_inc;

    logic                 arm;
    logic                 beat_ok;
    logic                 pkt_done;
    logic [1:0]           err_set;
    logic                 to_done;

    assign start_rise  = start & ~start_d;
    assign zero_run    = ~continuous && (num_pkts == '0);
    assign eff_len     = (pkt_len_bytes < LEN_W'(16)) ? (LEN_W+1)'(16) : {1'b0, pkt_len_bytes};
    assign nlines      = (eff_len + (LEN_W+1)'(7)) >> 3;
    assign last_k_next = LEN_W'(nlines - (LEN_W+1)'(2));
    assign exp_hdr     = {4'h0, seqnum, 16'(cfg_len), cfg_sid};
    assign ramp_word   = cfg_const + 32'(k);
    assign last_line   = (k == cfg_last_k);
    assign pkt_cnt_inc = pkt_cnt_q + PKT_CNT_W'(1);

    always_comb begin
        case (cfg_pattern)
            2'd0:    exp_data = '0;
            2'd1:    exp_data = '1;
            2'd2:    exp_data = {cfg_const, cfg_const};
            default: exp_data = {ramp_word, ramp_word};
        endcase
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) state <= IDLE;
        else            state <= next_state;
    end

    // Beats are refused while start is low so an aborting beat is never half-consumed.
    always_comb begin
        next_state = state;
        i_tready   = 1'b0;
        arm        = 1'b0;
        beat_ok    = 1'b0;
        pkt_done   = 1'b0;
        err_set    = 2'b00;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    arm        = 1'b1;
                    next_state = zero_run ? DONE : HDR;
                end
            end
            HDR: begin
                i_tready = start;
                if (!start) begin
                    next_state = DONE;
                end else if (i_tvalid) begin
                    err_set = {i_tlast, i_tdata != exp_hdr};
                    if (err_set != 2'b00) next_state = DONE;
                    else                  next_state = DATA;
                end
            end
            DATA: begin
                i_tready = start;
                if (!start) begin
                    next_state = DONE;
                end else if (i_tvalid) begin
                    err_set = {i_tlast != last_line, i_tdata != exp_data};
                    if (err_set != 2'b00) begin
                        next_state = DONE;
                    end else if (last_line) begin
                        pkt_done   = 1'b1;
                        next_state = (!cfg_cont && pkt_cnt_inc == cfg_num) ? DONE : HDR;
                    end else begin
                        beat_ok = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!start) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign to_done = (state == HDR || state == DATA) && (next_state == DONE);

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            start_d     <= 1'b0;
            cfg_cont    <= 1'b0;
            cfg_pattern <= 2'b00;
            cfg_const   <= '0;
            cfg_sid     <= '0;
            cfg_len     <= '0;
            cfg_num     <= '0;
            cfg_last_k  <= '0;
            seqnum      <= '0;
            k           <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 2'b00;
            pkt_cnt_q   <= '0;
            err_pkt_q   <= '0;
        end else begin
            start_d <= start;
            if (arm) begin
                cfg_cont    <= continuous;
                cfg_pattern <= pattern;
                cfg_const   <= const_word;
                cfg_sid     <= sid;
                cfg_len     <= pkt_len_bytes;
                cfg_num     <= num_pkts;
                cfg_last_k  <= last_k_next;
                seqnum      <= '0;
                k           <= '0;
                running_q   <= ~zero_run;
                done_q      <= zero_run;
                error_q     <= 2'b00;
                pkt_cnt_q   <= '0;
                err_pkt_q   <= '0;
            end
            if (beat_ok) k <= k + LEN_W'(1);
            if (pkt_done) begin
                k         <= '0;
                seqnum    <= seqnum + 12'd1;
                pkt_cnt_q <= pkt_cnt_inc;
            end
            if (err_set != 2'b00) begin
                error_q <= error_q | err_set;
                if (error_q == 2'b00) err_pkt_q <= pkt_cnt_q;
            end
            if (to_done) begin
                running_q <= 1'b0;
                done_q    <= 1'b1;
            end
        end
    end

    assign status  = {error_q, done_q, running_q};
    assign pkt_cnt = pkt_cnt_q;
    assign err_pkt = err_pkt_q;

endmodule
